mux_2_to_1_stream: RTL

Merges two valid/ready data streams, each carrying packets delimited by a last flag, onto one output stream. Arbitration is round-robin at packet granularity, and the output is registered. It is the merge-side counterpart of the 1-to-2 demultiplexer: it recombines the two split data paths, e.g. two PE result lanes, into a single stream toward the output buffer.

---
 rtl/mux_2_to_1_stream.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mux_2_to_1_stream.sv
// mux_2_to_1_stream: merges two valid/ready packet streams onto one registered
// output stream with round-robin arbitration at packet granularity.
// A granted packet owns the output until its last beat, so packets from the
// two channels are never interleaved.
// Optional feature macro: MUX_SRC_TAG_EN adds the Y_src source-channel tag.
module mux_2_to_1_stream #(
    parameter int unsigned MXwidth = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MXwidth-1:0] D0,
    input  logic               D0_valid,
    input  logic               D0_last,
    output logic               D0_ready,
    input  logic [MXwidth-1:0] D1,
    input  logic               D1_valid,
    input  logic               D1_last,
    output logic               D1_ready,
    output logic [MXwidth-1:0] Y,
    output logic               Y_valid,
    output logic               Y_last,
`ifdef MUX_SRC_TAG_EN
    output logic               Y_src,
`endif
    input  logic               Y_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic [MXwidth-1:0]   y_q, y_d;
    logic                 y_valid_q, y_valid_d;
    logic                 y_last_q, y_last_d;
`ifdef MUX_SRC_TAG_EN
    logic                 y_src_q, y_src_d;
`endif

    logic                 load_c;
    logic                 gnt_vld_c;
    logic                 gnt_ch_c;
    logic                 accept_c;
    logic                 sel_last_c;
    logic [MXwidth-1:0]   sel_data_c;

    // Output register can take a new beat when empty or draining this cycle.
    assign load_c = !y_valid_q || Y_ready;

    // Grant selection: packet lock wins, otherwise round-robin among requesters.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_ch_c  = 1'b0;
        unique case (state_q)
            LOCK0: begin
                gnt_vld_c = 1'b1;
                gnt_ch_c  = 1'b0;
            end
            LOCK1: begin
                gnt_vld_c = 1'b1;
                gnt_ch_c  = 1'b1;
            end
            default: begin
                if (D0_valid && D1_valid) begin
                    gnt_vld_c = 1'b1;
                    gnt_ch_c  = prio_q;
                end else if (D0_valid) begin
                    gnt_vld_c = 1'b1;
                    gnt_ch_c  = 1'b0;
                end else if (D1_valid) begin
                    gnt_vld_c = 1'b1;
                    gnt_ch_c  = 1'b1;
                end
            end
        endcase
    end

    assign D0_ready   = load_c && gnt_vld_c && !gnt_ch_c;
    assign D1_ready   = load_c && gnt_vld_c &&  gnt_ch_c;
    assign accept_c   = (D0_valid && D0_ready) || (D1_valid && D1_ready);
    assign sel_data_c = gnt_ch_c ? D1 : D0;
    assign sel_last_c = gnt_ch_c ? D1_last : D0_last;

    // Next-state, priority pointer and output register update.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_last_d  = y_last_q;
`ifdef MUX_SRC_TAG_EN
        y_src_d   = y_src_q;
`endif
        if (load_c) begin
            y_valid_d = 1'b0;
            if (accept_c) begin
                y_d       = sel_data_c;
                y_last_d  = sel_last_c;
                y_valid_d = 1'b1;
`ifdef MUX_SRC_TAG_EN
                y_src_d   = gnt_ch_c;
`endif
                if (sel_last_c) begin
                    state_d = IDLE;
                    prio_d  = 1'(~gnt_ch_c);
                end else begin
                    state_d = gnt_ch_c ? LOCK1 : LOCK0;
                end
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
`ifdef MUX_SRC_TAG_EN
            y_src_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
`ifdef MUX_SRC_TAG_EN
            y_src_q   <= y_src_d;
`endif
        end
    end

    assign Y       = y_q;
    assign Y_valid = y_valid_q;
    assign Y_last  = y_last_q;
`ifdef MUX_SRC_TAG_EN
    assign Y_src   = y_src_q;
`endif

endmodule
